credit_display_driver: RTL and testbench

- Upstream feeder for the 4:1 digit multiplexer in the vending machine display path.
- Converts the 14-bit binary credit/price value into four BCD digits with an iterative shift-add-3 (double-dabble) engine, one shift per clock.
- Generates the 2-bit digit-select scan sequence and the active-low anode enables for the 4-digit 7-segment display.
- Outputs d1..d4 and S wire directly to the mux inputs of the same names.

---
 rtl/credit_display_driver.sv | 160 ++++++++++++++++
 tb/tb_credit_display_driver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/credit_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : credit_display_driver
// Description : Converts a 14-bit credit/price value to four BCD digits with
//               an iterative shift-add-3 engine (one shift per clock). It also
//               generates the digit-select scan and the active-low anode
//               enables for a 4-digit 7-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
module credit_display_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] value,
  input  logic        load,
  output logic        busy,
  output logic        ovf,
  output logic [3:0]  d1,
  output logic [3:0]  d2,
  output logic [3:0]  d3,
  output logic [3:0]  d4,
  output logic [1:0]  S,
  output logic [3:0]  an
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [13:0]   bin_q, bin_d;     // binary operand, shifted out MSB first
  logic [15:0]   bcd_q, bcd_d;     // BCD scratch, thousands in [15:12]
  logic [3:0]    cnt_q, cnt_d;     // shifts performed so far
  logic          ovf_q, ovf_d;
  logic [15:0]   dig_q, dig_d;     // visible digits {d4,d3,d2,d1}
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    an_q, an_d;

  logic [15:0]   bcd_adj;
  logic [29:0]   shift_w;
  logic          blank4, blank3, blank2;

  // Conversion engine next-state: sample, shift-add-3 for 14 steps, publish.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    dig_d   = dig_q;

    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shift_w = {bcd_adj, bin_q} << 1;

    // Blanking cascades from the thousands digit; ones is always shown.
    blank4 = BLANK_LZ && (bcd_q[15:12] == 4'd0);
    blank3 = blank4 && (bcd_q[11:8] == 4'd0);
    blank2 = blank3 && (bcd_q[7:4] == 4'd0);

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          if (value > 14'd9999) begin
            bin_d = 14'd9999;
            ovf_d = 1'b1;
          end else begin
            bin_d = value;
            ovf_d = 1'b0;
          end
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = shift_w[29:14];
        bin_d = shift_w[13:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        dig_d[15:12] = blank4 ? 4'hF : bcd_q[15:12];
        dig_d[11:8]  = blank3 ? 4'hF : bcd_q[11:8];
        dig_d[7:4]   = blank2 ? 4'hF : bcd_q[7:4];
        dig_d[3:0]   = bcd_q[3:0];
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Conversion engine registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      dig_q   <= dig_d;
    end
  end

  // Scan next-state: advance the digit select on each prescaler wrap.
  always_comb begin
    presc_d = presc_q + 1'b1;
    sel_d   = sel_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      sel_d   = sel_q + 2'd1;
    end
    an_d = ~(4'b0001 << sel_q);
  end

  // Scan registers; anodes follow the select one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      sel_q   <= 2'd0;
      an_q    <= 4'b1111;
    end else begin
      presc_q <= presc_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign ovf  = ovf_q;
  assign d4   = dig_q[15:12];
  assign d3   = dig_q[11:8];
  assign d2   = dig_q[7:4];
  assign d1   = dig_q[3:0];
  assign S    = sel_q;
  assign an   = an_q;

endmodule
`default_nettype wire

// File: tb/tb_credit_display_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_credit_display_driver
// Description : Self-checking bench for credit_display_driver (blanking on
//               and off instances sharing one stimulus stream).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_credit_display_driver;

  localparam int DIV = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        load  = 1'b0;
  logic [13:0] value = '0;

  logic        busy_b, ovf_b, busy_n, ovf_n;
  logic [3:0]  d1_b, d2_b, d3_b, d4_b, d1_n, d2_n, d3_n, d4_n;
  logic [1:0]  s_b, s_n;
  logic [3:0]  an_b, an_n;
  logic [15:0] dig_b, dig_n;

  assign dig_b = {d4_b, d3_b, d2_b, d1_b};
  assign dig_n = {d4_n, d3_n, d2_n, d1_n};

  credit_display_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .busy(busy_b), .ovf(ovf_b),
    .d1(d1_b), .d2(d2_b), .d3(d3_b), .d4(d4_b),
    .S(s_b), .an(an_b)
  );

  credit_display_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .busy(busy_n), .ovf(ovf_n),
    .d1(d1_n), .d2(d2_n), .d3(d3_n), .d4(d4_n),
    .S(s_n), .an(an_n)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Reference: decimal digits by division, then leading-zero rules.
  function automatic logic [15:0] model(input int v, input bit blank);
    int c;
    logic [3:0] th, hu, te, on;
    c  = (v > 9999) ? 9999 : v;
    th = 4'(c / 1000);
    hu = 4'((c / 100) % 10);
    te = 4'((c / 10) % 10);
    on = 4'(c % 10);
    if (blank && th == 4'd0) th = 4'hF;
    if (blank && th == 4'hF && hu == 4'd0) hu = 4'hF;
    if (blank && hu == 4'hF && te == 4'd0) te = 4'hF;
    return {th, hu, te, on};
  endfunction

  // Scan reference: cycles since reset release determine the slot.
  int unsigned k;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  always @(negedge clk) begin
    logic [1:0] es;
    logic [3:0] ea;
    if (rst_n) begin
      es = 2'((k / DIV) % 4);
      ea = (k == 0) ? 4'b1111 : ~(4'b0001 << ((k - 1) / DIV % 4));
      check("scan_S", {30'd0, s_b}, {30'd0, es});
      check("scan_an", {28'd0, an_b}, {28'd0, ea});
      check("scan_S_nb", {30'd0, s_n}, {30'd0, es});
      check("scan_an_nb", {28'd0, an_n}, {28'd0, ea});
    end
  end

  // Drive a load at the current negedge and wait out the conversion.
  task automatic run_conv(input logic [13:0] v, output int n, output bit held);
    logic [15:0] prev_b, prev_n;
    prev_b = dig_b;
    prev_n = dig_n;
    value  = v;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n    = 0;
    held = 1'b1;
    while (busy_b === 1'b1 && n < 40) begin
      n++;
      if (dig_b !== prev_b || dig_n !== prev_n) held = 1'b0;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [13:0] v;
    logic [15:0] exp_b;
    logic [15:0] exp_n;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int n;
    bit held;
    int v;

    vecs[0]  = '{14'd1234,  16'h1234, 16'h1234, 1'b0};
    vecs[1]  = '{14'd7,     16'hFFF7, 16'h0007, 1'b0};
    vecs[2]  = '{14'd0,     16'hFFF0, 16'h0000, 1'b0};
    vecs[3]  = '{14'd1005,  16'h1005, 16'h1005, 1'b0};
    vecs[4]  = '{14'd12000, 16'h9999, 16'h9999, 1'b1};
    vecs[5]  = '{14'd9999,  16'h9999, 16'h9999, 1'b0};
    vecs[6]  = '{14'd10,    16'hFF10, 16'h0010, 1'b0};
    vecs[7]  = '{14'd100,   16'hF100, 16'h0100, 1'b0};
    vecs[8]  = '{14'd10000, 16'h9999, 16'h9999, 1'b1};
    vecs[9]  = '{14'd16383, 16'h9999, 16'h9999, 1'b1};
    vecs[10] = '{14'd90,    16'hFF90, 16'h0090, 1'b0};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy_b}, 32'd0);
    check("rst_ovf", {31'd0, ovf_b}, 32'd0);
    check("rst_dig", {16'd0, dig_b}, 32'd0);
    check("rst_S", {30'd0, s_b}, 32'd0);
    check("rst_an", {28'd0, an_b}, 32'hF);
    check("rst_dig_nb", {16'd0, dig_n}, 32'd0);
    check("rst_an_nb", {28'd0, an_n}, 32'hF);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Table-driven conversions, both blanking modes.
    for (int i = 0; i < 11; i++) begin
      run_conv(vecs[i].v, n, held);
      check("tbl_latency", n, 32'd15);
      check("tbl_held", {31'd0, held}, 32'd1);
      check("tbl_dig", {16'd0, dig_b}, {16'd0, vecs[i].exp_b});
      check("tbl_dig_nb", {16'd0, dig_n}, {16'd0, vecs[i].exp_n});
      check("tbl_ovf", {31'd0, ovf_b}, {31'd0, vecs[i].exp_ovf});
    end

    // Randomized values against the reference model.
    for (int i = 0; i < 25; i++) begin
      v = (i % 3 == 0) ? int'($urandom_range(0, 120)) : int'($urandom_range(0, 16383));
      run_conv(14'(v), n, held);
      check("rnd_latency", n, 32'd15);
      check("rnd_dig", {16'd0, dig_b}, {16'd0, model(v, 1'b1)});
      check("rnd_dig_nb", {16'd0, dig_n}, {16'd0, model(v, 1'b0)});
      check("rnd_ovf", {31'd0, ovf_b}, {31'd0, (v > 9999)});
    end

    // Loads while busy are dropped; a load in the first idle cycle is taken.
    value = 14'd4321;
    load  = 1'b1;
    @(negedge clk);
    n = 1;
    while (busy_b === 1'b1 && n < 40) begin
      if (n == 5) begin
        value = 14'd55;
        load  = 1'b1;
      end else if (n == 10) begin
        value = 14'd15000;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    load = 1'b0;
    check("drop_latency", n - 1, 32'd15);
    check("drop_dig", {16'd0, dig_b}, 32'h4321);
    check("drop_ovf", {31'd0, ovf_b}, 32'd0);
    run_conv(14'd321, n, held);
    check("idle_load_latency", n, 32'd15);
    check("idle_load_dig", {16'd0, dig_b}, 32'hF321);

    // Reset in the middle of a conversion.
    run_conv(14'd12000, n, held);
    check("pre_rst_ovf", {31'd0, ovf_b}, 32'd1);
    value = 14'd8888;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_busy", {31'd0, busy_b}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy_b}, 32'd0);
    check("mid_rst_ovf", {31'd0, ovf_b}, 32'd0);
    check("mid_rst_dig", {16'd0, dig_b}, 32'd0);
    check("mid_rst_S", {30'd0, s_b}, 32'd0);
    check("mid_rst_an", {28'd0, an_b}, 32'hF);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", {31'd0, busy_b}, 32'd0);
    check("post_rst_dig", {16'd0, dig_b}, 32'd0);
    check("post_rst_dig_nb", {16'd0, dig_n}, 32'd0);
    run_conv(14'd8888, n, held);
    check("post_rst_conv", {16'd0, dig_b}, 32'h8888);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
